// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
// Includes the state encoding, opcodes, datapath select codes and the per-state Moore output table.
package mc_ctrl_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXEC   = 4'd10,
    ST_I_WB     = 4'd11,
    ST_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Outputs that depend only on the state; ready/zero qualified enables are added in the top.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      ST_DECODE: c.alu_src_b = SRCB_IMM_SH2;
      ST_MEM_ADDR, ST_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      ST_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ST_I_WB: c.reg_write = 1'b1;
      ST_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_SUB;
        c.pc_src    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_src = PCSRC_JUMP;
        c.pc_en  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Bounded memory-wait counter: counts consecutive stalled cycles of a memory state
// and flags a timeout on the WAIT_MAX-th stalled cycle.
module mc_wait_timer
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  output logic timeout
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(WAIT_MAX - 1);

  logic [TIMER_W-1:0] count;

  // Any non-stalled cycle clears, so every new memory state starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + TIMER_W'(1);
    end else begin
      count <= '0;
    end
  end

  assign timeout = waiting && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Define MULTICYCLE_CTRL_JUMP_EN to enable the j instruction; otherwise opcode 000010 halts.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic       pc_en_o,
  output logic [1:0] pc_src_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [3:0] state_o,
  output logic       err_o
);

  state_t state;
  state_t nxt;
  ctrl_t  ctrl_q;
  logic   err_q;
  logic   mem_req;
  logic   accept;
  logic   waiting;
  logic   timeout;
  logic   fetch_accept;

  // A request is outstanding exactly in memory states; the first post-reset FETCH cycle has none.
  assign mem_req = ctrl_q.mem_read | ctrl_q.mem_write;
  assign accept  = mem_req & mem_ready_i;
  assign waiting = mem_req & ~mem_ready_i;

  mc_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_timer (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .waiting(waiting),
    .timeout(timeout)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_FETCH: begin
        if (accept)       nxt = ST_DECODE;
        else if (timeout) nxt = ST_HALT;
      end
      ST_DECODE: begin
        case (op_i)
          OP_RTYPE:     nxt = ST_R_EXEC;
          OP_LW, OP_SW: nxt = ST_MEM_ADDR;
          OP_BEQ:       nxt = ST_BRANCH;
          OP_ADDI:      nxt = ST_I_EXEC;
`ifdef MULTICYCLE_CTRL_JUMP_EN
          OP_J:         nxt = ST_JUMP;
`else
          OP_J:         nxt = ST_HALT;
`endif
          default:      nxt = ST_HALT;
        endcase
      end
      ST_MEM_ADDR: nxt = (op_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (accept)       nxt = ST_MEM_WB;
        else if (timeout) nxt = ST_HALT;
      end
      ST_MEM_WR: begin
        if (accept)       nxt = ST_FETCH;
        else if (timeout) nxt = ST_HALT;
      end
      ST_MEM_WB: nxt = ST_FETCH;
      ST_R_EXEC: nxt = ST_R_WB;
      ST_R_WB:   nxt = ST_FETCH;
      ST_I_EXEC: nxt = ST_I_WB;
      ST_I_WB:   nxt = ST_FETCH;
      ST_BRANCH: nxt = ST_FETCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
      ST_JUMP:   nxt = ST_FETCH;
`else
      ST_JUMP:   nxt = ST_HALT;
`endif
      ST_HALT:   nxt = ST_HALT;
      default:   nxt = ST_HALT;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_FETCH;
      ctrl_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= nxt;
      ctrl_q <= state_ctrl(nxt);
      err_q  <= err_q | (nxt == ST_HALT);
    end
  end

  assign fetch_accept = (state == ST_FETCH) & accept;

  assign pc_en_o      = rst_i & (ctrl_q.pc_en | fetch_accept | ((state == ST_BRANCH) & zero_i));
  assign ir_write_o   = rst_i & fetch_accept;
  assign pc_src_o     = ctrl_q.pc_src;
  assign iord_o       = ctrl_q.iord;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign reg_dst_o    = ctrl_q.reg_dst;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign reg_write_o  = ctrl_q.reg_write;
  assign alu_src_a_o  = ctrl_q.alu_src_a;
  assign alu_src_b_o  = ctrl_q.alu_src_b;
  assign alu_op_o     = ctrl_q.alu_op;
  assign state_o      = state;
  assign err_o        = err_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control sequencer for the multi-cycle MIPS datapath. It is the next step from the single-cycle core: one shared ALU, one shared instruction/data memory, and instruction/data registers between the stages.
- A Moore-style FSM walks each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK states.
- Memory accesses use a ready handshake, guarded by a bounded wait timer.
- The block drives every datapath mux select and register-enable.

## Interface
- WAIT_MAX, 8, maximum cycles a memory state may wait for mem_ready_i before fault (range 1..255)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- op_i  in  6  opcode field of instruction register; valid from DECODE onward
- mem_ready_i  in  1  memory completes current access this cycle
- zero_i  in  1  ALU zero flag
- pc_en_o  out  1  PC register write enable
- pc_src_o  out  2  0 ALU result, 1 ALUOut register, 2 jump target
- iord_o  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  instruction register load
- reg_dst_o  out  1  write register select: 0 rt, 1 rd
- mem_to_reg_o  out  1  write data select: 0 ALUOut, 1 MDR
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  1  0 PC, 1 rs data
- alu_src_b_o  out  2  0 rt data, 1 constant 4, 2 sign-ext imm, 3 sign-ext imm<<2
- alu_op_o  out  2  0 add, 1 sub, 2 use funct
- state_o  out  4  current state encoding (debug)
- err_o  out  1  sticky fault flag

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, HALT=15
- FETCH:
  - Drives mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=0, pc_src_o=0.
  - ir_write_o and pc_en_o equal mem_ready_i.
  - Goes to DECODE on ready, otherwise stays.
- DECODE: alu_src_a_o=0, alu_src_b_o=3, alu_op_o=0 (branch target precompute). Next state by op_i:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 001000 -> I_EXEC
  - 000010 -> JUMP
  - any other opcode -> HALT
- MEM_ADDR: src_a=1, src_b=2, add. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read_o=1, iord_o=1. On ready goes to MEM_WB.
- MEM_WB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1. Then FETCH.
- MEM_WR: mem_write_o=1, iord_o=1. On ready goes to FETCH.
- R_EXEC: src_a=1, src_b=0, alu_op=2. Then R_WB (reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0). Then FETCH.
- I_EXEC: src_a=1, src_b=2, add. Then I_WB (reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0). Then FETCH.
- BRANCH: src_a=1, src_b=0, sub, pc_src_o=1, pc_en_o=zero_i. Then FETCH.
- JUMP: pc_src_o=2, pc_en_o=1. Then FETCH.
- HALT: all enables 0, err_o=1. Stays until reset.
- Outputs not listed for a state are 0.

## Timing
- Wait timer (8-bit):
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle that state waits without mem_ready_i.
  - When it reaches WAIT_MAX with mem_ready_i still 0, next state is HALT and err_o sets.
  - If mem_ready_i is 1 in the same cycle the timer reaches WAIT_MAX, the ready wins and the FSM advances normally.
- Mem-ready cycle: pc_en_o, ir_write_o and the state advance all take effect at the same edge. mem_ready_i is sampled only in memory states and is ignored elsewhere.
- Latencies with zero wait states:
  - R-type 4 cycles, addi 4, lw 5, sw 4, beq 3, j 3.
  - Each memory wait cycle adds 1.
- Reset (rst_i=0, asynchronous):
  - state FETCH, timer 0, err_o 0.
  - All outputs forced 0 while rst_i=0, including FETCH's mem_read_o.
  - A reset asserted mid-instruction abandons that instruction; no partial register or memory write follows.
- First FETCH request appears the cycle after rst_i deasserts.

## Configuration
- MULTICYCLE_CTRL_JUMP_EN defined: opcode 000010 goes to JUMP as above.
- Not defined: JUMP state absent, 000010 is illegal (DECODE -> HALT, err_o=1), and pc_src_o never equals 2.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum with the encodings above;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALUOp constants and ALU-src-B select constants.
- One sub-module, mc_wait_timer, holds the bounded wait counter and timeout compare. State register and output decode stay in multicycle_ctrl.

## Test plan
- Reset: rst_i=0 for 3 cycles -> state_o=0, every output 0. After release, mem_read_o=1 the next cycle.
- add (op 000000), ready always 1 -> states 0,1,6,7,0. reg_write_o=1 with reg_dst_o=1 only in R_WB. pc_en_o pulses once.
- lw with ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then MEM_WB with mem_to_reg_o=1. Total 8 cycles.
- beq with zero_i=1 -> pc_en_o=1 and pc_src_o=1 in BRANCH. With zero_i=0 -> pc_en_o=0.
- WAIT_MAX=8, ready never asserted in FETCH -> HALT reached after 8 wait cycles, err_o=1 sticky until rst_i low. Ready arriving on the 8th cycle -> no fault.
- op 111111 -> HALT. op 000010 -> JUMP with the macro defined, HALT without it.
